horner_issue_sched: RTL and testbench



---
 rtl/horner_issue_sched.sv | 183 ++++++++++++++++++
 tb/tb_horner_issue_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/horner_issue_sched.sv
// Issue scheduler for the Horner datapath: FIFO-buffers operands and issues one srdyi pulse per evaluation.
// Optional macro HORNER_SCHED_SRDYO_WAIT_EN: WAIT ends on srdyo, guarded by a TIMEOUT watchdog that sets err.
module horner_issue_sched #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BUSY_CYCLES = 197,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        GlobalReset,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        srdyi,
  output logic [DATA_W-1:0]           x_out,
  input  logic                        srdyo,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = 8;
`ifdef HORNER_SCHED_SRDYO_WAIT_EN
  localparam int unsigned WAIT_LOAD = TIMEOUT;
`else
  localparam int unsigned WAIT_LOAD = BUSY_CYCLES;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_not_full;
  logic              w_push;
  logic              w_pop;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_srdyi;
  logic              w_srdyi_nxt;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] w_x_nxt;
  logic              r_busy;
`ifdef HORNER_SCHED_SRDYO_WAIT_EN
  logic              r_err;
  logic              w_err_nxt;
`endif
  logic              w_unused;

  // Not-full is held in a flop so in_ready never depends on this cycle's pop.
  assign in_ready = GlobalReset & r_not_full;
  assign w_push   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_not_full <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_not_full <= (w_count_nxt < CNT_W'(FIFO_DEPTH));
    end
  end

  // Issue FSM: IDLE pops and issues; WAIT counts down (or waits for srdyo) before the next issue.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_srdyi_nxt    = 1'b0;
    w_x_nxt        = r_x;
    w_pop          = 1'b0;
`ifdef HORNER_SCHED_SRDYO_WAIT_EN
    w_err_nxt      = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop          = 1'b1;
          w_x_nxt        = r_mem[r_rd_ptr];
          w_srdyi_nxt    = 1'b1;
          w_wait_cnt_nxt = WAIT_W'(WAIT_LOAD);
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
`ifdef HORNER_SCHED_SRDYO_WAIT_EN
        // A completion coinciding with expiry is a normal completion.
        if (srdyo) begin
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == WAIT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end
`else
        if (r_wait_cnt == WAIT_W'(1)) begin
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_wait_cnt <= '0;
      r_srdyi    <= 1'b0;
      r_x        <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      r_srdyi    <= w_srdyi_nxt;
      r_x        <= w_x_nxt;
      r_busy     <= (w_state_nxt == S_WAIT);
    end
  end

`ifdef HORNER_SCHED_SRDYO_WAIT_EN
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign srdyi      = r_srdyi;
  assign x_out      = r_x;
  assign busy       = r_busy;
  assign fifo_count = r_count;

  // Inputs and parameters that only one build variant consumes.
  assign w_unused = ^{srdyo, 32'(TIMEOUT), 32'(BUSY_CYCLES)};

endmodule

// File: tb/tb_horner_issue_sched.sv
// Directed bench for horner_issue_sched: vector table for the first issue, then burst, full-boundary,
// watchdog (when HORNER_SCHED_SRDYO_WAIT_EN is defined) and mid-WAIT reset sequences.
module tb_horner_issue_sched;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BUSY  = 197;
  localparam int unsigned TMO   = 255;
`ifdef HORNER_SCHED_SRDYO_WAIT_EN
  localparam int GAP      = 199;
  localparam int BUSY_LEN = 198;
`else
  localparam int GAP      = 198;
  localparam int BUSY_LEN = 197;
`endif

  logic          clk;
  logic          GlobalReset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          srdyi;
  logic [DW-1:0] x_out;
  logic          srdyo;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          err;

  int            total;
  int            bad;
  int            cyc;
  int            iss_cyc[$];
  logic [DW-1:0] iss_x[$];
  logic          resp_en;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          e_srdyi;
    logic          e_busy;
    logic [2:0]    e_cnt;
    logic          e_rdy;
    logic [DW-1:0] e_x;
  } vec_t;

  vec_t tbl[8];

  horner_issue_sched #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .BUSY_CYCLES(BUSY), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .srdyi(srdyi), .x_out(x_out), .srdyo(srdyo),
    .busy(busy), .fifo_count(fifo_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Log every issue with its cycle number and operand.
  always @(negedge clk) begin
    if (srdyi === 1'b1) begin
      iss_cyc.push_back(cyc);
      iss_x.push_back(x_out);
    end
  end

  // Datapath stand-in: returns srdyo 197 cycles after each srdyi when enabled.
  initial begin
    srdyo = 1'b0;
`ifdef HORNER_SCHED_SRDYO_WAIT_EN
    forever begin
      @(negedge clk);
      if (srdyi === 1'b1 && resp_en === 1'b1) begin
        repeat (BUSY) @(posedge clk);
        #1 srdyo = 1'b1;
        @(posedge clk);
        #1 srdyo = 1'b0;
      end
    end
`endif
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got total=%0d want finish", total);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
    #1;
  endtask

  int t0, bfall, xbad, idx, full_cnt, prev_cnt, rise, t_iss;

  initial begin
    GlobalReset = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    resp_en     = 1'b1;
    total       = 0;
    bad         = 0;

    tbl[0] = '{1'b1, 32'h3F80_0000, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 32'h0,         1'b0, 1'b0, 3'd1, 1'b1, 32'h0};
    tbl[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 3'd0, 1'b1, 32'h3F80_0000};
    tbl[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 3'd0, 1'b1, 32'h3F80_0000};
    tbl[4] = '{1'b1, 32'h4000_0000, 1'b0, 1'b1, 3'd0, 1'b1, 32'h3F80_0000};
    tbl[5] = '{1'b1, 32'hC0A0_0000, 1'b0, 1'b1, 3'd1, 1'b1, 32'h3F80_0000};
    tbl[6] = '{1'b0, 32'h0,         1'b0, 1'b1, 3'd2, 1'b1, 32'h3F80_0000};
    tbl[7] = '{1'b0, 32'h0,         1'b0, 1'b1, 3'd2, 1'b1, 32'h3F80_0000};

    // Reset values
    repeat (2) @(posedge clk);
    to_sample();
    chk("rst_srdyi", srdyi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_err", err, 0);
    to_drive();
    GlobalReset = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Single sample through the vector table
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      to_sample();
      chk($sformatf("vec%0d_srdyi", i), srdyi, tbl[i].e_srdyi);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_count", i), fifo_count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_x_out", i), x_out, tbl[i].e_x);
      to_drive();
    end

    // Busy window, operand hold and spacing to the second issue
    bfall = -1;
    xbad  = 0;
    for (int k = 0; k < 400 && iss_cyc.size() < 2; k++) begin
      to_sample();
      if (busy === 1'b0 && bfall < 0) bfall = cyc;
      if (iss_cyc.size() < 2 && x_out !== 32'h3F80_0000) xbad++;
    end
    chk("single_issue_count", iss_cyc.size(), 2);
    if (iss_cyc.size() >= 2) begin
      chk("single_latency", iss_cyc[0] - t0, 2);
      chk("single_gap", iss_cyc[1] - iss_cyc[0], GAP);
      chk("second_x", iss_x[1], 32'h4000_0000);
      chk("busy_len", bfall - iss_cyc[0], BUSY_LEN);
    end
    chk("x_held", xbad, 0);

    for (int k = 0; k < 500 && !(iss_cyc.size() >= 3 && busy === 1'b0); k++) to_sample();
    chk("third_issue_count", iss_cyc.size(), 3);
    if (iss_cyc.size() >= 3) begin
      chk("third_x", iss_x[2], 32'hC0A0_0000);
      chk("third_gap", iss_cyc[2] - iss_cyc[1], GAP);
    end

    // Burst of 6 into a depth-4 FIFO
    iss_cyc.delete();
    iss_x.delete();
    to_drive();
    idx      = 0;
    full_cnt = 99;
    in_valid = 1'b1;
    in_data  = 32'hB000_0000;
    for (int k = 0; k < 12; k++) begin
      to_sample();
      if (in_ready !== 1'b1) begin
        full_cnt = fifo_count;
        break;
      end
      idx++;
      to_drive();
      in_data = 32'hB000_0000 + 32'(idx);
    end
    chk("burst_pre_full", idx, 5);
    chk("burst_full_count", full_cnt, 4);

    // Full boundary: push refused in the pop cycle, accepted the next
    prev_cnt = fifo_count;
    rise     = 0;
    for (int k = 0; k < 300; k++) begin
      to_sample();
      if (in_ready === 1'b1) begin
        rise = 1;
        break;
      end
      prev_cnt = fifo_count;
    end
    chk("full_ready_rise", rise, 1);
    chk("pop_cycle_count", prev_cnt, 4);
    chk("after_pop_count", fifo_count, 3);
    chk("after_pop_srdyi", srdyi, 1);
    to_drive();
    in_valid = 1'b0;
    to_sample();
    chk("refill_count", fifo_count, 4);

    for (int k = 0; k < 6 * GAP + 100 && iss_cyc.size() < 6; k++) to_sample();
    chk("burst_issue_count", iss_cyc.size(), 6);
    for (int i = 0; i < iss_cyc.size() && i < 6; i++) begin
      chk($sformatf("burst_x%0d", i), iss_x[i], 32'hB000_0000 + 32'(i));
      if (i > 0) chk($sformatf("burst_gap%0d", i), iss_cyc[i] - iss_cyc[i-1], GAP);
    end
    for (int k = 0; k < 300 && busy !== 1'b0; k++) to_sample();
    chk("burst_drained", busy, 0);

`ifdef HORNER_SCHED_SRDYO_WAIT_EN
    // Watchdog: srdyo withheld, err at issue+255, scheduler resumes, err sticky
    iss_cyc.delete();
    iss_x.delete();
    resp_en = 1'b0;
    to_drive();
    in_valid = 1'b1;
    in_data  = 32'hC000_0001;
    to_drive();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && iss_cyc.size() < 1; k++) to_sample();
    chk("wd_issue", iss_cyc.size(), 1);
    if (iss_cyc.size() >= 1) begin
      t_iss = iss_cyc[0];
      for (int k = 0; k < 300 && cyc < t_iss + 254; k++) to_sample();
      chk("wd_err_before", err, 0);
      chk("wd_busy_before", busy, 1);
      to_sample();
      chk("wd_err_at_expiry", err, 1);
      chk("wd_busy_at_expiry", busy, 0);
    end
    resp_en = 1'b1;
    to_drive();
    in_valid = 1'b1;
    in_data  = 32'hC000_0002;
    to_drive();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && iss_cyc.size() < 2; k++) to_sample();
    chk("wd_resume_issue", iss_cyc.size(), 2);
    if (iss_cyc.size() >= 2) chk("wd_resume_x", iss_x[1], 32'hC000_0002);
    for (int k = 0; k < 400 && busy !== 1'b0; k++) to_sample();
    chk("wd_normal_done", busy, 0);
    chk("wd_err_sticky", err, 1);
`endif

    // Reset mid-WAIT with 2 samples queued
    iss_cyc.delete();
    iss_x.delete();
    to_drive();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hD000_0000 + 32'(i);
      to_drive();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) to_sample();
    chk("pre_rst_count", fifo_count, 2);
    chk("pre_rst_busy", busy, 1);
    GlobalReset = 1'b0;
    #1;
    chk("async_rst_srdyi", srdyi, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", fifo_count, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_x_out", x_out, 0);
    chk("async_rst_err", err, 0);
    repeat (3) @(posedge clk);
    #1 GlobalReset = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 300; k++) to_sample();
    chk("post_rst_issues", iss_cyc.size(), 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
